// File: rtl/dmem_responder_if.sv
// Load/store port between the core's memory-request logic (master) and the
// data-memory responder (slave): one request channel, one response channel.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-oriented data memory answering the core's load/store port with a
// programmable wait-state delay. Optional fault detection: DMEM_ERR_EN.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | ready for a request; nothing outstanding
//   ST_WAIT | request latched, wait-state down-counter running
//   ST_RESP | access done, response held until rsp_ready
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    dmem_responder_if.slave        bus,
    output logic [15:0]            test_value
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wcnt;
    logic        ready_en;
    logic        hs;
    logic        exec;
    logic        fault;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];

    assign idx = addr_q[AW+1:2];

`ifdef DMEM_ERR_EN
    assign fault = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q[31:AW+2], addr_q[1:0]};
    assign fault = 1'b0;
`endif

    // ready_en keeps req_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        exec          = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        hs            = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = ready_en;
                hs            = bus.req_valid && ready_en;
                if (hs) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt == 4'd0) begin
                    exec      = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The counter starts at WAIT_STATES so the execute edge lands one cycle
    // after the last wait state, giving rsp_valid after edge N+1+WAIT_STATES.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt    <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (hs) begin
            wcnt    <= 4'(WAIT_STATES);
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end else if (state == ST_WAIT && wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (exec) begin
            rdata_q <= (we_q || fault) ? 32'h0 : mem[idx];
            err_q   <= fault;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (exec && we_q && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign test_value    = mem[0][15:0];
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_STATES=2, 64 words).
module tb_dmem_responder;
    localparam int DW = 64;
    localparam int WS = 2;

    logic        clk;
    logic        rst;
    logic [15:0] test_value;
    int          n_checks;
    int          n_errors;
    logic [31:0] rd;
    logic        er;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .test_value (test_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request/response; with stall>0 the response is held for that many
    // cycles while a competing store to 0x10 is offered on the request side.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int stall,
                        output logic [31:0] rdata, output logic err);
        int   n;
        logic rdy_hi;
        logic stable;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.rsp_ready = (stall == 0);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("req_ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = addr ^ 32'h4;
        bus.req_wdata = ~wdata;
        bus.req_be    = ~be;
        rdy_hi = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 40) begin
            rdy_hi |= bus.req_ready;
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(WS + 1));
        rdy_hi |= bus.req_ready;
        rdata  = bus.rsp_rdata;
        err    = bus.rsp_err;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_addr  = 32'h10;
            bus.req_wdata = 32'h5555_5555;
            bus.req_be    = 4'hF;
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_rdata !== rdata || bus.rsp_err !== err) stable = 1'b0;
            rdy_hi |= bus.req_ready;
        end
        if (stall > 0) begin
            check("stall_stable", 32'(stable), 32'd1);
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        check("ready_low_busy", 32'(rdy_hi), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_accept", {bus.req_ready, bus.rsp_valid}, 32'b10);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata[29:0]}, 32'd0);
        check("rst_test_value", 32'(test_value), 32'd0);
        rst = 1'b1;
        #1;
        check("release_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("release_ready_high", 32'(bus.req_ready), 32'd1);

        xfer(1'b0, 32'h00, 32'h0, 4'h0, 0, rd, er);
        check("load0_data", rd, 32'h0);
        check("load0_err", 32'(er), 32'd0);

        xfer(1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        check("store_rdata_zero", rd, 32'h0);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 0, rd, er);
        check("load4_data", rd, 32'hDEAD_BEEF);

        xfer(1'b1, 32'h00, 32'h1234_5678, 4'hF, 0, rd, er);
        xfer(1'b1, 32'h00, 32'h0000_00AB, 4'h1, 0, rd, er);
        check("test_value", 32'(test_value), 32'h56AB);
        xfer(1'b0, 32'h00, 32'h0, 4'h0, 0, rd, er);
        check("merge_word0", rd, 32'h1234_56AB);

        xfer(1'b1, 32'h04, 32'h0000_0000, 4'h0, 0, rd, er);
        xfer(1'b1, 32'h04, 32'hAABB_CCDD, 4'hA, 0, rd, er);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 10, rd, er);
        check("be_lanes_stall", rd, 32'hAAAD_CCEF);
        check("stall_err", 32'(er), 32'd0);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("stalled_req_ignored", rd, 32'h0);

`ifdef DMEM_ERR_EN
        xfer(1'b1, 32'h02, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
        check("misalign_err", 32'(er), 32'd1);
        xfer(1'b0, 32'h00, 32'h0, 4'h0, 0, rd, er);
        check("misalign_no_write", rd, 32'h1234_56AB);
        xfer(1'b0, 32'(4 * DW), 32'h0, 4'h0, 0, rd, er);
        check("oob_err", 32'(er), 32'd1);
        check("oob_data", rd, 32'h0);
`else
        xfer(1'b0, 32'(4 * DW), 32'h0, 4'h0, 0, rd, er);
        check("wrap_data", rd, 32'h1234_56AB);
        check("wrap_err", 32'(er), 32'd0);
`endif

        // reset while the store is still counting wait states
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h08;
        bus.req_wdata = 32'hFFFF_FFFF;
        bus.req_be    = 4'hF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("wait_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("wait_rst_ready", 32'(bus.req_ready), 32'd0);
        check("wait_rst_test_value", 32'(test_value), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("wait_rst_ready_back", 32'(bus.req_ready), 32'd1);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 0, rd, er);
        check("abandoned_store", rd, 32'h0);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 0, rd, er);
        check("mem_cleared", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
